// File: rtl/io_uart_pkg.sv
// Shared types and status-word layout for the memory-mapped UART transmitter.
package io_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int ST_ACTIVE    = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int CMD_BIT      = 31;

endpackage

// File: rtl/io_uart_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module io_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter on the controller's I/O port: byte FIFO, frame FSM,
// sticky overflow flag and a registered status word.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] io_data_out,
    input  logic        io_write_en,
    output logic [31:0] io_rdata,
    output logic        io_busy,
    output logic        uart_tx
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          overflow, overflow_next;

    logic          wr_push, wr_cmd, push_acc;
    logic          pop, load, shift_en, bit_inc, baud_clr, tx_next, baud_done;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count, count_next;
    logic          fifo_full, fifo_empty;
    logic [31:0]   status_next;

    io_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_push),
        .pop   (pop),
        .din   (io_data_out[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_push   = io_write_en && !io_data_out[CMD_BIT];
    assign wr_cmd    = io_write_en &&  io_data_out[CMD_BIT];
    assign push_acc  = wr_push && (!fifo_full || pop);
    assign baud_done = (baud_cnt == BAUD_MAX);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        baud_clr   = 1'b0;
        tx_next    = uart_tx;
        unique case (state)
            IDLE: begin
                baud_clr = 1'b1;
                if (!fifo_empty) begin
                    state_next = START;
                    pop        = 1'b1;
                    load       = 1'b1;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    baud_clr   = 1'b1;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_clr = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_inc  = 1'b1;
                        shift_en = 1'b1;
                        tx_next  = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_clr = 1'b1;
                    // Chain straight into the next start bit so queued bytes leave gap-free.
                    if (!fifo_empty) begin
                        state_next = START;
                        pop        = 1'b1;
                        load       = 1'b1;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status reflects the post-edge state so a write is visible right after it is sampled.
    always_comb begin
        count_next    = fifo_count + CW'(push_acc) - CW'(pop);
        overflow_next = overflow;
        if (wr_cmd) begin
            overflow_next = 1'b0;
        end else if (wr_push && !push_acc) begin
            overflow_next = 1'b1;
        end
        status_next                       = '0;
        status_next[ST_ACTIVE]            = (state_next != IDLE);
        status_next[ST_EMPTY]             = (count_next == '0);
        status_next[ST_FULL]              = (count_next == CW'(FIFO_DEPTH));
        status_next[ST_OVF]               = overflow_next;
        status_next[ST_COUNT_LSB +: 4]    = 4'(count_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            uart_tx  <= 1'b1;
            overflow <= 1'b0;
            io_rdata <= 32'h0000_0002;
            io_busy  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_clr ? '0 : baud_cnt + BW'(1);
            if (load)         bit_idx <= '0;
            else if (bit_inc) bit_idx <= bit_idx + 3'd1;
            if (load)          shift_q <= fifo_dout;
            else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
            uart_tx  <= tx_next;
            overflow <= overflow_next;
            io_rdata <= status_next;
            io_busy  <= (count_next == CW'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_io_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] io_data_out;
    logic        io_write_en;
    logic [31:0] io_rdata;
    logic        io_busy;
    logic        uart_tx;

    int n_cmp = 0;
    int n_err = 0;

    io_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_data_out (io_data_out),
        .io_write_en (io_write_en),
        .io_rdata    (io_rdata),
        .io_busy     (io_busy),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at the first sample of the start bit; returns at the
    // sample right after the stop bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk(tag, {31'd0, uart_tx}, {31'd0, f[i/4]});
            step();
        end
    endtask

    task automatic wr(input logic [31:0] d);
        io_data_out = d;
        io_write_en = 1'b1;
        step();
        io_write_en = 1'b0;
        io_data_out = '0;
    endtask

    initial begin
        logic saw_low;
        reset       = 1'b1;
        io_data_out = '0;
        io_write_en = 1'b0;

        step();
        step();
        chk("rst_tx",    {31'd0, uart_tx}, 32'd1);
        chk("rst_busy",  {31'd0, io_busy}, 32'd0);
        chk("rst_rdata", io_rdata, 32'h0000_0002);
        reset = 1'b0;
        step();
        chk("idle_rdata", io_rdata, 32'h0000_0002);

        // single byte
        wr(32'h0000_0055);
        chk("wr_rdata", io_rdata, 32'h0000_0100);
        chk("wr_tx",    {31'd0, uart_tx}, 32'd1);
        step();
        chk("start_rdata", io_rdata, 32'h0000_0003);
        check_frame(8'h55, "frame_55");
        chk("done_rdata", io_rdata, 32'h0000_0002);
        chk("done_tx",    {31'd0, uart_tx}, 32'd1);

        // fill and overflow: edges 1..6
        for (int i = 0; i < 6; i++) begin
            wr(32'h11 + 32'(i));
            if (i == 3) chk("busy_w4",  {31'd0, io_busy}, 32'd0);
            if (i == 4) begin
                chk("busy_w5",  {31'd0, io_busy}, 32'd1);
                chk("rdata_w5", io_rdata, 32'h0000_0405);
            end
        end
        chk("ovf_rdata", io_rdata, 32'h0000_040D);
        chk("ovf_busy",  {31'd0, io_busy}, 32'd1);

        // clear overflow at edge 7
        wr(32'h8000_0000);
        chk("clr_rdata", io_rdata, 32'h0000_0405);
        chk("clr_busy",  {31'd0, io_busy}, 32'd1);

        // frame 0x11 started at edge 2; next start at edge 42
        repeat (35) step();
        chk("pop_busy",  {31'd0, io_busy}, 32'd0);
        chk("pop_rdata", io_rdata, 32'h0000_0301);
        check_frame(8'h12, "fifo_12");
        check_frame(8'h13, "fifo_13");
        check_frame(8'h14, "fifo_14");
        check_frame(8'h15, "fifo_15");
        chk("drain_rdata", io_rdata, 32'h0000_0002);
        chk("drain_tx",    {31'd0, uart_tx}, 32'd1);

        // back-to-back frames
        wr(32'h0000_00A5);
        wr(32'h0000_003C);
        check_frame(8'hA5, "b2b_a5");
        check_frame(8'h3C, "b2b_3c");
        chk("b2b_rdata", io_rdata, 32'h0000_0002);

        // reset mid-frame during data bit 3 (0xF7 has bit3 = 0)
        wr(32'h0000_00F7);
        wr(32'h0000_0077);
        repeat (17) step();
        chk("mid_bit3", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        step();
        chk("mid_rst_tx",    {31'd0, uart_tx}, 32'd1);
        chk("mid_rst_rdata", io_rdata, 32'h0000_0002);
        chk("mid_rst_busy",  {31'd0, io_busy}, 32'd0);
        reset = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, saw_low}, 32'd0);
        chk("post_rst_rdata", io_rdata, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter that sits on the I/O side of `ram_controller` and answers the I/O port that the controller drives for address 0xFFFFFFFF. Core stores to the I/O address arrive as `io_write_en` pulses carrying a byte, which is queued in a small FIFO and serialised 8N1 on `uart_tx`. Core loads from the I/O address return a registered status word on `io_rdata`. `io_busy` applies backpressure when the FIFO is full.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Must be a power of two, 2..8.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_data_out`  in  32  write data from the controller; [7:0] is the byte, [31] is the command flag.
- `io_write_en`  in  1  one-cycle write strobe from the controller.
- `io_rdata`  out  32  registered status word, read by the controller.
- `io_busy`  out  1  high while the FIFO is full.
- `uart_tx`  out  1  serial line; idles high.

## Operation

- **Write with `io_data_out[31]=0`**: push `io_data_out[7:0]` into the FIFO.
  - The push is accepted if count < `FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and the sticky `overflow` flag is set.
- **Write with `io_data_out[31]=1`**: command. Clears `overflow`. Nothing is enqueued.
- **`io_rdata` status word**, registered and updated every cycle:
  - bit0 `tx_active`: FSM is not IDLE.
  - bit1 `fifo_empty`.
  - bit2 `fifo_full`.
  - bit3 `overflow`.
  - [11:8] fill count, zero-extended.
  - All other bits 0.
- **`io_busy`**: registered, equal to (count == `FIFO_DEPTH`).
- **State machine**, states IDLE, START, DATA, STOP:
  - IDLE → START when the FIFO is non-empty. Pop the head into the shift register; `uart_tx`=0.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA shifts out 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit index counts the bits.
  - DATA → STOP after bit 7; `uart_tx`=1.
  - STOP lasts `CLKS_PER_BIT` cycles. It then goes directly to START (pop) if the FIFO is non-empty, with no idle gap; otherwise it goes to IDLE.
- **Baud counter**: counts 0..`CLKS_PER_BIT`-1, width $clog2(`CLKS_PER_BIT`). Reloads to 0 on every state or bit change.
- **`uart_tx`** is registered; no combinational path from any input.

## Timing

- **Reset values**: `uart_tx`=1, `io_busy`=0, `io_rdata`=32'h0000_0002 (empty), FSM=IDLE, FIFO count=0, `overflow`=0.
- **Write latency**:
  - Write sampled at edge k → count and `io_rdata` updated after edge k.
  - If IDLE, pop and START happen at edge k+1, so `uart_tx` falls after edge k+1.
- **Frame length**: exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- **`io_busy`**:
  - Rises in the cycle after the write that makes count = `FIFO_DEPTH`.
  - Falls in the cycle after the pop that frees a slot.
- **Simultaneous events**:
  - Push and pop in the same cycle leave the count unchanged, and the push is accepted even when full.
  - Command write and overflow in the same cycle cannot occur, since a command never enqueues.
- **Reset mid-frame**: at the next edge `uart_tx`=1, the FIFO is emptied, the frame is abandoned, and `overflow` is cleared.
- **FIFO pointers** are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is one bit wider.

## Structure

- **Package `io_uart_pkg`** holds:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Status bit index constants: `ST_ACTIVE`=0, `ST_EMPTY`=1, `ST_FULL`=2, `ST_OVF`=3, `ST_COUNT_LSB`=8.
  - `CMD_BIT`=31.
- **Sub-module `io_uart_fifo`**: parameterised synchronous FIFO with push, pop, din, dout, count, full, empty. First-word-fall-through, so dout is valid whenever not empty.
- The top level contains the FSM, baud counter, shift register, status register and overflow flag.

## Test plan

All scenarios run with `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

- **Reset**: hold `reset` 2 cycles → `uart_tx`=1, `io_busy`=0, `io_rdata`=32'h00000002.
- **Single byte**: write 32'h00000055 →
  - `uart_tx` falls 1 cycle after the write is sampled.
  - Line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total.
  - `io_rdata` then returns to 32'h00000002.
- **Fill and overflow**: 6 writes on consecutive cycles while IDLE →
  - 5 bytes accepted: 1 in the shifter, 4 in the FIFO.
  - `io_busy`=1 after the 5th write.
  - 6th write is dropped.
  - `io_rdata`=32'h0000040D (count 4, overflow, full, active).
- **Back-to-back frames**: bytes 0xA5, 0x3C → 80 contiguous cycles with no idle-high gap between the STOP bit and the next START bit.
- **Clear overflow**: after the overflow case, write 32'h80000000 → `io_rdata`[3]=0 next cycle, FIFO contents unchanged.
- **Reset mid-frame**: assert `reset` during DATA bit 3 → `uart_tx`=1 next cycle, count 0, and no further frame is sent after reset is released.
